// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared defaults for the data-memory arbiter and its round-robin picker.
//   DEF_NREQ / DEF_AW / DEF_DW are the default requester count, word-address
//   width and data width. idx_t is a requester index sized for DEF_NREQ.
package dmem_arb_pkg;

  localparam int DEF_NREQ = 2;
  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 32;

  // The width is kept at least 1 so that a single-requester build still has a legal type.
  localparam int DEF_IW = (DEF_NREQ > 1) ? $clog2(DEF_NREQ) : 1;

  typedef logic [DEF_IW-1:0] idx_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick
//   Purely combinational round-robin selector. It can be reused for any
//   shared resource.
//   Ports:
//     req  in  N  : request vector
//     last in  IW : index granted most recently
//     gnt  out N  : one-hot grant (all zero when no request)
//     idx  out IW : encoded index of the grant
//     any  out 1  : some request was granted
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // The search walks last+1, last+2, ... modulo N. The first active request wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between NREQ valid/ready requesters.
//   Arbitration is round-robin, with one grant per cycle. Read data comes back
//   one cycle after the grant and is tagged with the owning requester.
//   Ports:
//     clk, reset (async, active-low)
//     req_valid/req_we [NREQ], req_addr [NREQ*AW], req_wdata [NREQ*DW]
//     req_ready [NREQ] : one-hot grant
//     rsp_valid [NREQ], rsp_rdata [DW] : read response, 0 when idle
//     m_addr, m_wr_dat, rd_en, wr_en : memory drive; m_rd_dat : memory data (1-cycle latency)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_wr_dat,
  output logic              rd_en,
  output logic              wr_en,
  input  logic [DW-1:0]     m_rd_dat
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            run;
  logic            rd_pend;
  logic [IW-1:0]   rd_owner;
  logic [IW-1:0]   last_grant;
  logic [NREQ-1:0] req_live;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any_gnt;
  logic            gnt_we;

  // run clears asynchronously with reset and sets at the first clock edge
  // where reset is high. Reset release therefore takes effect synchronously,
  // and no request can be granted while reset is low.
  assign req_live = run ? req_valid : '0;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req  (req_live),
    .last (last_grant),
    .gnt  (gnt),
    .idx  (gnt_idx),
    .any  (any_gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    m_addr   = '0;
    m_wr_dat = '0;
    gnt_we   = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    if (any_gnt) begin
      m_addr   = req_addr[int'(gnt_idx)*AW +: AW];
      m_wr_dat = req_wdata[int'(gnt_idx)*DW +: DW];
      gnt_we   = req_we[gnt_idx];
      rd_en    = ~gnt_we;
      wr_en    = gnt_we;
    end
  end

  // Read data passes straight through from the memory. The memory already
  // registers it, so an extra stage here would only add latency.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (rd_pend) begin
      rsp_valid[rd_owner] = 1'b1;
      rsp_rdata           = m_rd_dat;
    end
  end

  // A new read may be accepted in the same cycle the previous response is shown.
  // In that case rd_pend stays high and only rd_owner moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      rd_pend    <= 1'b0;
      rd_owner   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      run     <= 1'b1;
      rd_pend <= any_gnt & ~gnt_we;
      if (any_gnt) begin
        last_grant <= gnt_idx;
      end
      if (any_gnt && !gnt_we) begin
        rd_owner <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with NREQ=2. A behavioural memory model
//   drives m_rd_dat. Each stimulus step checks the grant and memory drive
//   signals, and queues any expected read response. A separate monitor checks
//   rsp_valid/rsp_rdata on every cycle against that queue.
module tb_dmem_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wr_dat;
  logic              rd_en;
  logic              wr_en;
  logic [DW-1:0]     m_rd_dat = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [1:0] owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .m_addr    (m_addr),
    .m_wr_dat  (m_wr_dat),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .m_rd_dat  (m_rd_dat)
  );

  // Memory model. Unwritten words read as a fixed pattern: 0x40 holds
  // DEADBEEF, and every other address holds A5A5_00_<addr>.
  logic [31:0] mem [256];
  bit          written [256];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h40) return 32'hDEADBEEF;
    return {16'hA5A5, 8'h00, a};
  endfunction

  always @(posedge clk) begin
    if (wr_en) begin
      mem[m_addr[7:0]]     <= m_wr_dat;
      written[m_addr[7:0]] <= 1'b1;
    end
    if (rd_en) begin
      m_rd_dat <= written[m_addr[7:0]] ? mem[m_addr[7:0]] : init_word(m_addr[7:0]);
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor. Any cycle without a queued expectation must show an idle response.
  always @(negedge clk) begin
    rsp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      compare("rsp_valid", 32'(rsp_valid), 32'(e.owner));
      compare("rsp_rdata", rsp_rdata, e.data);
    end else begin
      compare("rsp_valid_idle", 32'(rsp_valid), 32'h0);
      compare("rsp_rdata_idle", rsp_rdata, 32'h0);
    end
  end

  task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [1:0] we,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] w0, input logic [31:0] w1);
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] e_ready, input logic e_rd,
                             input logic e_wr, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic e_rsp,
                             input logic [31:0] e_rdata);
    rsp_t r;
    @(negedge clk);
    compare({tag, ".req_ready"}, 32'(req_ready), 32'(e_ready));
    compare({tag, ".rd_en"}, 32'(rd_en), 32'(e_rd));
    compare({tag, ".wr_en"}, 32'(wr_en), 32'(e_wr));
    compare({tag, ".m_addr"}, m_addr, e_addr);
    compare({tag, ".m_wr_dat"}, m_wr_dat, e_wdata);
    if (e_rsp) begin
      r.cyc   = cyc + 1;
      r.owner = e_ready;
      r.data  = e_rdata;
      exp_q.push_back(r);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 reset = 1'b0;

    // reset held low while both requesters ask
    applyStimulus(1'b0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("rst_hold0", 2'b00, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("rst_hold1", 2'b00, 0, 0, 0, 0, 0, 0);
    // release is taken synchronously, so there is no grant in the release cycle
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("rst_release", 2'b00, 0, 0, 0, 0, 0, 0);

    // contention: grants alternate, starting with requester 0
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
      if (i % 2 == 0)
        checkOutput("contend_r0", 2'b01, 1, 0, 32'h10, 0, 1, 32'hA5A50010);
      else
        checkOutput("contend_r1", 2'b10, 1, 0, 32'h20, 0, 1, 32'hA5A50020);
    end

    applyStimulus(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("idle0", 2'b00, 0, 0, 0, 0, 0, 0);

    // single read of the preloaded word
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h40, 0, 0, 0);
    checkOutput("single_read", 2'b01, 1, 0, 32'h40, 0, 1, 32'hDEADBEEF);

    // write by req1, then a read by req0 of the same address in the next cycle
    applyStimulus(1'b1, 2'b10, 2'b10, 0, 32'h80, 0, 32'h12345678);
    checkOutput("write_r1", 2'b10, 0, 1, 32'h80, 32'h12345678, 0, 0);
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h80, 0, 0, 0);
    checkOutput("raw_read_r0", 2'b01, 1, 0, 32'h80, 0, 1, 32'h12345678);

    // make last_grant=1, so that req0 is preferred next
    applyStimulus(1'b1, 2'b10, 2'b00, 0, 32'h20, 0, 0);
    checkOutput("prime_r1", 2'b10, 1, 0, 32'h20, 0, 1, 32'hA5A50020);
    // req1 asks for one cycle while req0 wins, then withdraws
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("withdraw_r0", 2'b01, 1, 0, 32'h10, 0, 1, 32'hA5A50010);
    applyStimulus(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("withdraw_drop", 2'b00, 0, 0, 0, 0, 0, 0);
    // last_grant must now be 0, so req1 wins the next contention
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("after_withdraw", 2'b10, 1, 0, 32'h20, 0, 1, 32'hA5A50020);

    // reset mid-read: grant req0 (last_grant=0), then kill the read before the edge
    applyStimulus(1'b1, 2'b01, 2'b00, 32'h40, 0, 0, 0);
    checkOutput("mid_read_grant", 2'b01, 1, 0, 32'h40, 0, 0, 0);
    #1 reset = 1'b0;
    applyStimulus(1'b0, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("mid_read_hold", 2'b00, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("mid_read_release", 2'b00, 0, 0, 0, 0, 0, 0);
    // last_grant has returned to NREQ-1, so req0 has priority again
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("post_reset_prio", 2'b01, 1, 0, 32'h10, 0, 1, 32'hA5A50010);
    applyStimulus(1'b1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0);
    checkOutput("post_reset_next", 2'b10, 1, 0, 32'h20, 0, 1, 32'hA5A50020);

    applyStimulus(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("idle1", 2'b00, 0, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 2'b00, 2'b00, 0, 0, 0, 0);
    checkOutput("idle2", 2'b00, 0, 0, 0, 0, 0, 0);

    compare("rsp_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single-port `data_memory` between `NREQ` requesters, e.g. the core load/store unit and the debug/preload port.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin and picks one request per cycle.
- The block drives the memory port directly. Read data returns one cycle after grant, tagged to the owning requester.
- Back-to-back requests sustain full throughput.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (2..8)
- `AW`, 32: address width (word-address domain of `data_memory`)
- `DW`, 32: data width

Ports:
- `clk` in 1: clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in NREQ: per-requester request valid
- `req_we` in NREQ: 1 = write, 0 = read
- `req_addr` in NREQ*AW: packed addresses, requester i at [i*AW +: AW]
- `req_wdata` in NREQ*DW: packed write data
- `req_ready` out NREQ: one-hot grant; request accepted when valid & ready
- `rsp_valid` out NREQ: one-hot read-response strobe
- `rsp_rdata` out DW: read data, valid when any `rsp_valid` bit is set
- `m_addr` out AW: memory address
- `m_wr_dat` out DW: memory write data
- `rd_en` out 1: memory read enable
- `wr_en` out 1: memory write enable
- `m_rd_dat` in DW: memory read data, registered inside memory with 1-cycle latency

## Operation
- **Arbitration:** round-robin over `req_valid`.
  - Search starts at `last_grant+1` and wraps modulo NREQ.
  - `last_grant` updates only on an accepted request.
  - Reset value of `last_grant` = NREQ-1, so requester 0 has first priority.
- **Grant:** combinational. Exactly one `req_ready` bit is high when any `req_valid` is high; otherwise all bits are 0.
  - No `req_ready` is asserted while `reset` is low.
- **Memory drive:** for the granted requester, `m_addr`/`m_wr_dat` are muxed from its request.
  - `wr_en` = granted & we; `rd_en` = granted & !we.
  - With no grant, `m_addr`, `m_wr_dat`, `rd_en` and `wr_en` are all 0.
- **Writes:** complete at the grant edge. Writes produce no response.
- **Reads:**
  - At the grant edge, register `rd_pend` = 1 and `rd_owner` = granted index.
  - Next cycle: `rsp_valid[rd_owner]` = 1 and `rsp_rdata` = `m_rd_dat` (passthrough, no extra register).
  - `rsp_valid` is derived from `rd_pend`/`rd_owner`.
- **Pipelining:** a new request may be granted in the same cycle a previous read response is presented. At most one read is in flight in any cycle.
- **Requester stability:** once `req_valid` is high, the requester holds `addr`/`we`/`wdata` stable until ready. A requester may drop valid without being granted (not an error).
- **Read-after-write, same address, consecutive cycles:** the read returns the new data, because the memory write lands at edge N and the read samples at edge N+1.
- **Response data idle value:** `rsp_rdata` = 0 whenever no `rsp_valid` bit is set.

## Timing
- Grant latency: 0 cycles (same cycle as valid, if selected).
- Read latency: 1 cycle from accepting edge to `rsp_valid` high; the response lasts exactly 1 cycle with no backpressure.
- Throughput: 1 request/cycle aggregate.
  - Under full contention each of k active requesters is granted once every k cycles.
  - Worst-case wait is NREQ-1 cycles.
- Reset (async assert, low):
  - `rd_pend` = 0, `rd_owner` = 0, `last_grant` = NREQ-1.
  - All outputs go to 0 immediately, including a pending `rsp_valid`.
  - An in-flight read is dropped and not replayed.
  - Deassertion is used synchronously: the first grant is possible in the cycle after the first edge with `reset` high.
- Simultaneous grant of a read and presentation of a prior response: both happen in the same cycle. `rd_pend` stays 1 and `rd_owner` updates.

## Structure
- Package `dmem_arb_pkg`: default `NREQ`/`AW`/`DW` localparams and an `idx_t` typedef (`$clog2(NREQ)` bits).
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and the last index; outputs are a one-hot grant and the encoded index. It is reusable for other shared resources.
- `dmem_arbiter` contains the `rr_pick` instance, the request mux, and the `rd_pend`/`rd_owner`/`last_grant` registers. Expected size is 150–250 lines.

## Test plan
- **Reset:** hold `reset` low with all `req_valid`=11 → `req_ready`=00, `rd_en`=`wr_en`=0, `rsp_valid`=00. Release reset → first grant goes to requester 0.
- **Single read:** preload `mem[0x40]`=`0xDEADBEEF`; req0 reads addr `0x40` → `req_ready[0]`=1, `rd_en`=1 that cycle; next cycle `rsp_valid`=01, `rsp_rdata`=`0xDEADBEEF`.
- **Contention:** both requesters are held valid for 6 cycles with reads to `0x10` (req0) and `0x20` (req1) → grants alternate 0,1,0,1,0,1. Responses alternate owners with the matching data, one cycle later.
- **Write then read:** req1 writes `0x12345678` to `0x80`; next cycle req0 reads `0x80` → response `0x12345678` to req0 only. No `rsp_valid` is produced for the write.
- **Reset mid-read:** grant a read and assert `reset` low before the next edge → `rsp_valid` stays 00. After release, `last_grant` = NREQ-1 and requester 0 has priority.
- **Withdrawn request:** req1 is valid for one cycle while req0 is granted, then drops → no grant to req1, `last_grant` = 0, and no response for req1.
